// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: frame/key/collision inputs and game-state outputs of game_state_ctrl
interface game_state_ctrl_if;
  logic        frame_tick;
  logic [15:0] keycode;
  logic        collision;
  logic [1:0]  state;
  logic [1:0]  hp;
  logic [1:0]  menu_sel;
  logic [3:0]  round;
  logic        phase_start;
  logic        invuln;
  logic [9:0]  time_left;
  modport master (
    output frame_tick, keycode, collision,
    input  state, hp, menu_sel, round, phase_start, invuln, time_left
  );
  modport slave (
    input  frame_tick, keycode, collision,
    output state, hp, menu_sel, round, phase_start, invuln, time_left
  );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: title/menu/dodge/gameover FSM with hp, menu cursor, round count and dodge timer
// Ports: clk, reset (sync active-high); bus.slave inputs frame_tick, keycode {prev,latest}, collision;
// bus.slave outputs state, hp, menu_sel, round, phase_start, invuln, time_left (all registered).
module game_state_ctrl #(
  parameter int DODGE_FRAMES = 600,
  parameter int IFRAMES      = 30,
  parameter int HP_MAX       = 3
) (
  input logic          clk,
  input logic          reset,
  game_state_ctrl_if.slave bus
);
  typedef enum logic [1:0] {TITLE, MENU, DODGE, GAMEOVER} state_t;
  localparam int IW = $clog2(IFRAMES + 1);
  state_t        r_state;
  logic [1:0]    r_hp;
  logic [1:0]    r_menu_sel;
  logic [3:0]    r_round;
  logic          r_phase_start;
  logic          r_invuln;
  logic [9:0]    r_time_left;
  logic [IW-1:0] r_icnt;
  logic [15:0]   r_key_prev;
  logic          w_key_ev;
  logic          w_enter;
  logic          w_left;
  logic          w_right;
  logic          w_hit;
  logic          w_dead;
  logic          w_last;
  logic [IW-1:0] w_icnt_n;
  // a new make code only: break prefixes and an unchanged scan history are ignored
  assign w_key_ev = (bus.keycode != r_key_prev) && (bus.keycode[15:8] != 8'hF0);
  assign w_enter  = w_key_ev && bus.keycode[7:0] == 8'h5A;
  assign w_left   = w_key_ev && bus.keycode[7:0] == 8'h6B;
  assign w_right  = w_key_ev && bus.keycode[7:0] == 8'h74;
  assign w_hit    = bus.collision && !r_invuln;
  assign w_dead   = w_hit && r_hp == 2'd1;
  assign w_last   = bus.frame_tick && r_time_left == 10'd1;
  assign w_icnt_n = w_hit ? IW'(IFRAMES) :
                    (bus.frame_tick && r_icnt != '0) ? r_icnt - IW'(1) : r_icnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= TITLE;
      r_hp          <= 2'(HP_MAX);
      r_menu_sel    <= 2'd0;
      r_round       <= 4'd0;
      r_phase_start <= 1'b0;
      r_invuln      <= 1'b0;
      r_time_left   <= 10'd0;
      r_icnt        <= '0;
      r_key_prev    <= 16'h0000;
    end else begin
      r_key_prev    <= bus.keycode;
      r_phase_start <= 1'b0;
      case (r_state)
        TITLE: if (w_enter) begin
          r_state    <= MENU;
          r_menu_sel <= 2'd0;
        end
        MENU: begin
          if (w_left) r_menu_sel <= r_menu_sel == 2'd0 ? 2'd2 : r_menu_sel - 2'd1;
          if (w_right) r_menu_sel <= r_menu_sel == 2'd2 ? 2'd0 : r_menu_sel + 2'd1;
          if (w_enter) begin
            r_state       <= DODGE;
            r_time_left   <= 10'(DODGE_FRAMES);
            r_phase_start <= 1'b1;
          end
        end
        DODGE: begin
          r_hp     <= r_hp - {1'b0, w_hit};
          r_icnt   <= w_icnt_n;
          r_invuln <= w_icnt_n != '0;
          if (bus.frame_tick) r_time_left <= r_time_left - 10'd1;
          // a fatal hit outranks a simultaneous last-frame tick
          if (w_dead) begin
            r_state     <= GAMEOVER;
            r_time_left <= 10'd0;
            r_icnt      <= '0;
            r_invuln    <= 1'b0;
          end else if (w_last) begin
            r_state  <= MENU;
            r_round  <= r_round == 4'd15 ? 4'd15 : r_round + 4'd1;
            r_icnt   <= '0;
            r_invuln <= 1'b0;
          end
        end
        GAMEOVER: if (w_enter) begin
          r_state    <= TITLE;
          r_hp       <= 2'(HP_MAX);
          r_round    <= 4'd0;
          r_menu_sel <= 2'd0;
        end
      endcase
    end
  end
  assign bus.state       = r_state;
  assign bus.hp          = r_hp;
  assign bus.menu_sel    = r_menu_sel;
  assign bus.round       = r_round;
  assign bus.phase_start = r_phase_start;
  assign bus.invuln      = r_invuln;
  assign bus.time_left   = r_time_left;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenarios plus random stimulus checked against a behavioural game model
module tb_game_state_ctrl;
  localparam int DF  = 600;
  localparam int IFR = 30;
  localparam int HPM = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  game_state_ctrl_if bus();
  game_state_ctrl #(.DODGE_FRAMES(DF), .IFRAMES(IFR), .HP_MAX(HPM)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_tests = 0;
  int n_fail = 0;
  int m_state, m_hp, m_sel, m_round, m_time, m_inv, m_ps;
  logic [15:0] m_prev;
  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic void model(input bit fr, input logic [15:0] key, input bit col, input bit rst);
    bit ev, hit;
    int k;
    if (rst) begin
      m_state = 0; m_hp = HPM; m_sel = 0; m_round = 0; m_time = 0; m_inv = 0; m_ps = 0; m_prev = 0;
      return;
    end
    ev = key != m_prev && key[15:8] != 8'hF0;
    k = ev ? int'(key[7:0]) : -1;
    m_prev = key;
    m_ps = 0;
    if (m_state == 0) begin
      if (k == 'h5A) begin m_state = 1; m_sel = 0; end
    end else if (m_state == 1) begin
      if (k == 'h6B) m_sel = (m_sel + 2) % 3;
      if (k == 'h74) m_sel = (m_sel + 1) % 3;
      if (k == 'h5A) begin m_state = 2; m_time = DF; m_ps = 1; end
    end else if (m_state == 2) begin
      hit = col && m_inv == 0;
      if (hit) begin m_hp--; m_inv = IFR; end
      else if (fr && m_inv > 0) m_inv--;
      if (fr) m_time--;
      if (hit && m_hp == 0) begin
        m_state = 3; m_time = 0; m_inv = 0;
      end else if (fr && m_time == 0) begin
        m_state = 1; m_inv = 0; m_round = m_round < 15 ? m_round + 1 : 15;
      end
    end else if (k == 'h5A) begin
      m_state = 0; m_hp = HPM; m_round = 0; m_sel = 0;
    end
  endfunction
  task automatic cyc(input bit fr, input logic [15:0] key, input bit col, input bit rst);
    bus.frame_tick = fr;
    bus.keycode = key;
    bus.collision = col;
    reset = rst;
    model(fr, key, col, rst);
    @(posedge clk);
    #1;
    chk("state", int'(bus.state), m_state);
    chk("hp", int'(bus.hp), m_hp);
    chk("menu_sel", int'(bus.menu_sel), m_sel);
    chk("round", int'(bus.round), m_round);
    chk("phase_start", int'(bus.phase_start), m_ps);
    chk("invuln", int'(bus.invuln), int'(m_inv != 0));
    chk("time_left", int'(bus.time_left), m_time);
  endtask
  initial begin
    logic [15:0] k;
    bus.frame_tick = 1'b0;
    bus.keycode = 16'h0;
    bus.collision = 1'b0;
    cyc(0, 16'h005A, 1, 1);
    cyc(0, 16'h0000, 0, 1);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_hp", int'(bus.hp), HPM);
    cyc(0, 16'h005A, 0, 0);
    chk("title_to_menu", int'(bus.state), 1);
    cyc(0, 16'hF05A, 0, 0);
    cyc(0, 16'h0074, 0, 0);
    chk("right_sel1", int'(bus.menu_sel), 1);
    cyc(0, 16'h0074, 0, 0);
    cyc(0, 16'h006B, 0, 0);
    cyc(0, 16'hF06B, 0, 0);
    cyc(0, 16'h006B, 0, 0);
    chk("left_wrap", int'(bus.menu_sel), 2);
    cyc(0, 16'h0074, 0, 0);
    chk("right_wrap", int'(bus.menu_sel), 0);
    cyc(0, 16'h005A, 0, 0);
    chk("phase_start", int'(bus.phase_start), 1);
    chk("time_load", int'(bus.time_left), DF);
    repeat (DF) cyc(1, 16'h005A, 0, 0);
    chk("round_end_state", int'(bus.state), 1);
    chk("round_end_round", int'(bus.round), 1);
    chk("round_end_time", int'(bus.time_left), 0);
    cyc(0, 16'hF05A, 0, 0);
    cyc(0, 16'h005A, 0, 0);
    cyc(1, 16'h005A, 1, 0);
    chk("first_hit", int'(bus.hp), 2);
    repeat (39) cyc(1, 16'h005A, 1, 0);
    chk("second_hit", int'(bus.hp), 1);
    for (int i = 0; i < 2000 && m_time > 1; i++) cyc(1, 16'h005A, 0, 0);
    cyc(1, 16'h005A, 1, 0);
    chk("tie_state", int'(bus.state), 3);
    chk("tie_hp", int'(bus.hp), 0);
    chk("tie_round", int'(bus.round), 1);
    cyc(0, 16'hF05A, 1, 0);
    cyc(0, 16'h005A, 0, 0);
    chk("restart_state", int'(bus.state), 0);
    chk("restart_hp", int'(bus.hp), HPM);
    chk("restart_round", int'(bus.round), 0);
    cyc(0, 16'hF05A, 0, 0);
    cyc(0, 16'h005A, 0, 0);
    cyc(0, 16'hF05A, 0, 0);
    cyc(0, 16'h005A, 0, 0);
    repeat (340) cyc(1, 16'h005A, 0, 0);
    cyc(1, 16'h005A, 1, 0);
    repeat (9) cyc(1, 16'h005A, 0, 0);
    chk("mid_time", int'(bus.time_left), 250);
    chk("mid_invuln", int'(bus.invuln), 1);
    cyc(1, 16'h0074, 1, 1);
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_time", int'(bus.time_left), 0);
    chk("mid_rst_invuln", int'(bus.invuln), 0);
    k = 16'h0;
    for (int i = 0; i < 20000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) k = 16'h005A;
      else if (r < 6) k = 16'hF05A;
      else if (r < 7) k = 16'h006B;
      else if (r < 8) k = 16'h0074;
      else if (r < 9) k = {k[7:0], 8'h6B};
      else if (r < 10) k = 16'($urandom);
      cyc(bit'($urandom_range(0, 1)), k, $urandom_range(0, 249) == 0, $urandom_range(0, 4999) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter DODGE_FRAMES, default 600, sets the dodge-phase length in frame ticks (10 s at 60 Hz).
REQ-002 Parameter IFRAMES, default 30, sets the invulnerability window after a hit, in frame ticks.
REQ-003 Parameter HP_MAX, default 3, is the hit-point value loaded at reset and on restart.
REQ-004 clk  in  1  pixel/system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_tick  in  1  one-clk pulse per video frame.
REQ-007 keycode  in  16  PS/2 scan history {previous byte, latest byte}.
REQ-008 collision  in  1  level, player/bullet overlap this pixel.
REQ-009 state  out  2  0=TITLE, 1=MENU, 2=DODGE, 3=GAMEOVER; drives border, player and bullet sprites.
REQ-010 hp  out  2  remaining hit points.
REQ-011 menu_sel  out  2  highlighted action: 0=FIGHT, 1=ACT, 2=MERCY.
REQ-012 round  out  4  completed dodge phases, saturating.
REQ-013 phase_start  out  1  one-clk pulse on entry to DODGE; bullet generator restarts on it.
REQ-014 invuln  out  1  high while the invulnerability counter is non-zero.
REQ-015 time_left  out  10  remaining dodge frames; 0 outside DODGE.

Function
REQ-016 Key event: one-clk strobe when keycode differs from its value registered on the previous clk and keycode[15:8] != 8'hF0; break codes and repeats of an unchanged keycode produce no event.
REQ-017 Decoded keys use keycode[7:0]: ENTER=8'h5A, LEFT=8'h6B, RIGHT=8'h74; other codes produce no action.
REQ-018 TITLE: ENTER event -> MENU on the next clk, with menu_sel=0.
REQ-019 MENU: LEFT decrements menu_sel, 0 wraps to 2; RIGHT increments it, 2 wraps to 0; menu_sel never holds 3.
REQ-020 MENU: ENTER event -> DODGE on the next clk; time_left loads DODGE_FRAMES; phase_start is high for exactly that clk.
REQ-021 DODGE: each frame_tick decrements time_left; when a tick occurs with time_left=1, time_left becomes 0, state goes to MENU, and round increments, saturating at 15.
REQ-022 DODGE: collision=1 with invuln=0 decrements hp by 1 and loads the invulnerability counter with IFRAMES in the same clk; collision while invuln=1 is ignored.
REQ-023 The invulnerability counter decrements on frame_tick while non-zero; it is cleared on any exit from DODGE.
REQ-024 DODGE: the clk after hp becomes 0 -> GAMEOVER; time_left is cleared to 0.
REQ-025 If a hit that takes hp to 0 and the last-frame tick land in the same clk, GAMEOVER wins, round does not increment, and no MENU entry occurs.
REQ-026 hp never underflows; a decrement from 0 is impossible because state is no longer DODGE.
REQ-027 Key events in DODGE and collision outside DODGE have no effect.
REQ-028 GAMEOVER: ENTER event -> TITLE; hp reloads HP_MAX, round clears to 0, menu_sel clears to 0.
REQ-029 All outputs are registered; state changes take effect one clk after the causing event.

Reset
REQ-030 While reset=1 on a rising clk edge: state=TITLE, hp=HP_MAX, menu_sel=0, round=0, phase_start=0, invuln=0, time_left=0, invulnerability counter=0, key-history register=16'h0000.
REQ-031 Reset overrides every other input, including in mid-DODGE and on a pending key event; the first key event is evaluated on the clk after reset deasserts.

Verification
REQ-032 Reset, then keycode 16'h005A -> state 0->1 one clk later; then 16'hF05A -> no change; then 16'h5A5A... followed by 16'h0074 -> menu_sel 0->1.
REQ-033 In MENU with menu_sel=0, LEFT event -> menu_sel=2; RIGHT event -> menu_sel=0.
REQ-034 ENTER in MENU -> phase_start high for 1 clk, time_left=600; after 600 frame_ticks -> state=1, round=1, time_left=0.
REQ-035 DODGE with collision held high for 40 frames -> hp 3->2 at the first clk, invuln high for 30 ticks, then a second hit gives hp=1.
REQ-036 hp=1 and a collision coincident with the tick at time_left=1 -> hp=0, state=3, round unchanged; ENTER -> state=0, hp=3, round=0.
REQ-037 Reset asserted mid-DODGE with time_left=250, invuln=1 -> all outputs at the REQ-030 values on the next clk.
